// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, active-low hex ROM contents and polarity helper
package seg7_pkg;
  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_UNLIT = 7'h7F;
  localparam seg_t HEX_ROM [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  // ROM patterns are active-low; invert them for active-high boards
  function automatic seg_t seg_pol(seg_t s, bit active_low);
    return active_low ? s : ~s;
  endfunction
endpackage

// File: rtl/seg7_sync_rom.sv
// seg7_sync_rom: registered-address hex-to-segment ROM, one cycle latency
module seg7_sync_rom
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] addr,
  output seg_t       data
);
  logic [3:0] addr_q;
  // capture the address; the lookup behind it is purely combinational
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_q <= '0;
    else addr_q <= addr;
  assign data = HEX_ROM[addr_q];
endmodule

// File: rtl/seg7_scan_rom.sv
// seg7_scan_rom: double-buffered multi-digit hex scan driver (optional LEADING_ZERO_BLANK_EN)
module seg7_scan_rom
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1024,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    update_ack
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam bit SEG_LOW = ACTIVE_LOW_SEG != 0;
  localparam bit AN_LOW = ACTIVE_LOW_AN != 0;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [VW-1:0] disp, pend;
  logic [NUM_DIGITS-1:0] disp_dp, pend_dp, an1;
  logic pend_flag, tc, frame_end, blank, dp1, blank1;
  logic [3:0] nib;
  seg_t rom_seg;
  assign tc = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = tc && idx == IW'(NUM_DIGITS - 1);
  assign nib = disp[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = idx != '0 && (disp >> (4 * idx)) == '0;
`else
  assign blank = 1'b0;
`endif
  // refresh counter and digit index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end
  // pending/display double buffer, committed only at frame boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp       <= '0;
      disp_dp    <= '0;
      pend       <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      update_ack <= 1'b0;
    end else begin
      update_ack <= frame_end && (load || pend_flag);
      if (frame_end) begin
        if (load || pend_flag) begin
          disp    <= load ? value : pend;
          disp_dp <= load ? dp_in : pend_dp;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend      <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
    end
  seg7_sync_rom u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (nib),
    .data (rom_seg)
  );
  // stage 1: dp, blank and digit enable travel alongside the ROM address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dp1    <= 1'b0;
      blank1 <= 1'b0;
      an1    <= '0;
    end else begin
      dp1    <= disp_dp[idx];
      blank1 <= blank;
      an1    <= NUM_DIGITS'(1) << idx;
    end
  // stage 2: polarity-corrected outputs, dark until the pipeline has filled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg <= seg_pol(SEG_UNLIT, SEG_LOW);
      dp  <= SEG_LOW;
      an  <= AN_LOW ? '1 : '0;
    end else begin
      seg <= seg_pol((an1 == '0 || blank1) ? SEG_UNLIT : rom_seg, SEG_LOW);
      dp  <= dp1 ^ SEG_LOW;
      an  <= AN_LOW ? ~an1 : an1;
    end
endmodule

// File: doc/seg7_scan_rom.md
Name: seg7_scan_rom

Overview:
Parametrised multi-digit hex-to-seven-segment scan driver. It holds a double-buffered display value and time-multiplexes NUM_DIGITS digits onto one shared segment bus. Each digit is decoded through a registered-address synchronous ROM stage. It sits between register-mapped status logic and board-level common-anode/cathode LED displays.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..16)
REFRESH_DIV, 1024, clock cycles each digit is held active (>=2)
ACTIVE_LOW_SEG, 1, 1: seg/dp lit when 0; 0: lit when 1
ACTIVE_LOW_AN, 1, 1: an bit asserted when 0; 0: asserted when 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load  in  1  capture value/dp_in into pending buffer
value  in  4*NUM_DIGITS  hex digits; digit k = value[4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point per digit
seg  out  7  segments, bit6=a .. bit0=g
dp  out  1  decimal point of active digit
an  out  NUM_DIGITS  one-hot digit enable
update_ack  out  1  one-cycle pulse when pending buffer is committed to display

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: seg = all unlit; dp = unlit; an = all deasserted; update_ack = 0. Refresh counter, digit index, display buffer, pending buffer and pending flag are all 0.
- Refresh counter runs 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances.
- Digit index scans 0,1,..,NUM_DIGITS-1, then back to 0.
- Frame boundary is the terminal-count cycle in which the index is NUM_DIGITS-1.
- Pipeline: index changes in cycle t. In t+1 the selected nibble and dp are registered (ROM address register). In t+2 seg, dp and an update together. an is delayed two stages to stay aligned with seg.
- Latency from reset release to first lit digit: 2 cycles. The display buffer after reset is 0, so digit 0 shows "0".
- ROM, active-low encoding, digits 0..F: 01 4F 12 06 4C 24 20 0F 00 04 08 60 31 42 30 38 (hex). With ACTIVE_LOW_SEG=0 the output is bitwise inverted. dp follows the same polarity rule.
- load=1 writes value/dp_in into the pending buffer and sets the pending flag. Multiple loads within one frame: last wins.
- At a frame boundary with the pending flag set, pending is copied to the display buffer, the flag is cleared, and update_ack pulses in the following cycle. Display content therefore never changes mid-frame (no tearing).
- load in the frame-boundary cycle: the incoming value is committed directly, the flag ends clear, and update_ack pulses.
- No pending update at a boundary: no commit, no update_ack.
- NUM_DIGITS=1: every terminal count is a frame boundary.
- Reset mid-operation: all state clears immediately. Pending data is discarded and no update_ack is emitted.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: any digit more significant than the highest nonzero digit of the display buffer shows all segments unlit. Its dp still follows dp_in, and an still scans. Digit 0 is never blanked. Blank decision is computed from the display buffer and pipelined with the nibble.
- Undefined: all digits always decoded; behaviour identical to the base spec.

Decomposition:
- Package seg7_pkg: SEG_W=7; seg_t typedef; 16-entry active-low ROM constant; unlit constant 7'h7F; polarity-apply function.
- Sub-module seg7_sync_rom: registered 4-bit address in, 7-bit decoded segments out, one-cycle latency.
- Counter, scan, double buffer and an-alignment stay in the top.

Test Plan:
- Reset, NUM_DIGITS=4, REFRESH_DIV=4, load value=16'h1234 -> after commit: digit0 seg=7'h4C (4), an=4'b1110; digit1 seg=7'h06 (3), an=4'b1101; each held 4 cycles.
- Load 16'hABCD mid-frame -> display keeps 1234 until frame boundary; update_ack one pulse; next frame shows D,C,B,A = 42,31,60,08.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 displayed; single update_ack.
- load asserted exactly at the frame-boundary cycle with 16'h0F0F -> committed immediately; next frame digit0 seg=7'h38, digit1 seg=7'h01.
- Assert rst_n low while pending is set -> seg=7'h7F, an=4'hF, no update_ack; first frame after release shows 0000.
- LEADING_ZERO_BLANK_EN, value=16'h0050, dp_in=4'b1000 -> digits 3 and 2: seg=7'h7F; digit 3 dp lit; digit1 seg=7'h24; digit0 seg=7'h01.
